// File: rtl/parking_pkg.sv
// Shared types for the parking gate beam sequencer: FSM states, per-edge step
// result and the pure next-state rule table.
package parking_pkg;

    localparam int DEFAULT_TIMEOUT_CYCLES = 1000;
    localparam int DEFAULT_TW             = 10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_IN_O   = 3'd1,
        ST_IN_OI  = 3'd2,
        ST_IN_I   = 3'd3,
        ST_OUT_I  = 3'd4,
        ST_OUT_IO = 3'd5,
        ST_OUT_O  = 3'd6,
        ST_FAULT  = 3'd7
    } gate_state_t;

    typedef struct packed {
        gate_state_t next_state;
        logic        entry_evt;
        logic        exit_evt;
    } gate_step_t;

    function automatic logic is_in_progress(input gate_state_t st);
        return (st != ST_IDLE) && (st != ST_FAULT);
    endfunction

    // Beam-pattern rules; {o,i} is the synchronized (outer, inner) pair.
    function automatic gate_step_t beam_step(input gate_state_t st, input logic [1:0] oi);
        gate_step_t r;
        r.next_state = st;
        r.entry_evt  = 1'b0;
        r.exit_evt   = 1'b0;
        case (st)
            ST_IDLE: begin
                case (oi)
                    2'b10:   r.next_state = ST_IN_O;
                    2'b01:   r.next_state = ST_OUT_I;
                    2'b11:   r.next_state = ST_FAULT;
                    default: r.next_state = st;
                endcase
            end
            ST_IN_O: begin
                case (oi)
                    2'b11:   r.next_state = ST_IN_OI;
                    2'b00:   r.next_state = ST_IDLE;
                    2'b01:   r.next_state = ST_FAULT;
                    default: r.next_state = st;
                endcase
            end
            ST_IN_OI: begin
                case (oi)
                    2'b01:   r.next_state = ST_IN_I;
                    2'b10:   r.next_state = ST_IN_O;
                    2'b00:   r.next_state = ST_IDLE;
                    default: r.next_state = st;
                endcase
            end
            ST_IN_I: begin
                case (oi)
                    2'b00: begin
                        r.next_state = ST_IDLE;
                        r.entry_evt  = 1'b1;
                    end
                    2'b11:   r.next_state = ST_IN_OI;
                    2'b10:   r.next_state = ST_FAULT;
                    default: r.next_state = st;
                endcase
            end
            ST_OUT_I: begin
                case (oi)
                    2'b11:   r.next_state = ST_OUT_IO;
                    2'b00:   r.next_state = ST_IDLE;
                    2'b10:   r.next_state = ST_FAULT;
                    default: r.next_state = st;
                endcase
            end
            ST_OUT_IO: begin
                case (oi)
                    2'b10:   r.next_state = ST_OUT_O;
                    2'b01:   r.next_state = ST_OUT_I;
                    2'b00:   r.next_state = ST_IDLE;
                    default: r.next_state = st;
                endcase
            end
            ST_OUT_O: begin
                case (oi)
                    2'b00: begin
                        r.next_state = ST_IDLE;
                        r.exit_evt   = 1'b1;
                    end
                    2'b11:   r.next_state = ST_OUT_IO;
                    2'b01:   r.next_state = ST_FAULT;
                    default: r.next_state = st;
                endcase
            end
            ST_FAULT: begin
                case (oi)
                    2'b00:   r.next_state = ST_IDLE;
                    default: r.next_state = st;
                endcase
            end
            default: r.next_state = ST_FAULT;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gate_beam_sequencer_if.sv
// Beam inputs and vehicle event outputs of the gate sequencer; master drives
// the beams, slave is the sequencer.
interface gate_beam_sequencer_if;
    logic beam_outer;
    logic beam_inner;
    logic entry_pulse;
    logic exit_pulse;
    logic busy;
    logic fault;

    modport master (
        output beam_outer, beam_inner,
        input  entry_pulse, exit_pulse, busy, fault
    );

    modport slave (
        input  beam_outer, beam_inner,
        output entry_pulse, exit_pulse, busy, fault
    );
endinterface

// File: rtl/beam_sync.sv
// Two-flop synchronizer for one asynchronous IR beam input.
module beam_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out
);
    logic meta_r;
    logic sync_r;

    // Metastability filter chain, cleared by reset so a stale beam is never seen
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= async_in;
            sync_r <= meta_r;
        end
    end

    assign sync_out = sync_r;
endmodule

// File: rtl/gate_beam_sequencer.sv
// Parking gate direction sequencer: decodes the outer/inner beam order into
// one-cycle entry/exit events, with a per-state dwell timeout into FAULT.
module gate_beam_sequencer
    import parking_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int TW             = DEFAULT_TW
) (
    input  logic                 clk,
    input  logic                 reset,
    gate_beam_sequencer_if.slave bus
);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);

    logic          outer_sync_s;
    logic          inner_sync_s;
    gate_state_t   state_r;
    logic [TW-1:0] tmo_cnt_r;
    logic          entry_pulse_r;
    logic          exit_pulse_r;
    gate_step_t    step_s;
    logic          in_progress_s;
    logic          timeout_s;

    beam_sync u_sync_outer (
        .clk      (clk),
        .reset    (reset),
        .async_in (bus.beam_outer),
        .sync_out (outer_sync_s)
    );

    beam_sync u_sync_inner (
        .clk      (clk),
        .reset    (reset),
        .async_in (bus.beam_inner),
        .sync_out (inner_sync_s)
    );

    assign step_s        = beam_step(state_r, {outer_sync_s, inner_sync_s});
    assign in_progress_s = is_in_progress(state_r);
    assign timeout_s     = (tmo_cnt_r == TMO_LAST);

    // Sequencer state, dwell counter and event pulses; a real transition beats a timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            tmo_cnt_r     <= {TW{1'b0}};
            entry_pulse_r <= 1'b0;
            exit_pulse_r  <= 1'b0;
        end else if (step_s.next_state != state_r) begin
            state_r       <= step_s.next_state;
            tmo_cnt_r     <= {TW{1'b0}};
            entry_pulse_r <= step_s.entry_evt;
            exit_pulse_r  <= step_s.exit_evt;
        end else if (in_progress_s && timeout_s) begin
            state_r       <= ST_FAULT;
            tmo_cnt_r     <= {TW{1'b0}};
            entry_pulse_r <= 1'b0;
            exit_pulse_r  <= 1'b0;
        end else if (in_progress_s) begin
            state_r       <= state_r;
            tmo_cnt_r     <= tmo_cnt_r + TMO_ONE;
            entry_pulse_r <= 1'b0;
            exit_pulse_r  <= 1'b0;
        end else begin
            state_r       <= state_r;
            tmo_cnt_r     <= {TW{1'b0}};
            entry_pulse_r <= 1'b0;
            exit_pulse_r  <= 1'b0;
        end
    end

    assign bus.entry_pulse = entry_pulse_r;
    assign bus.exit_pulse  = exit_pulse_r;
    assign bus.busy        = in_progress_s;
    assign bus.fault       = (state_r == ST_FAULT);
endmodule

// File: tb/tb_gate_beam_sequencer.sv
// Bench for gate_beam_sequencer: vector table, hand-written corner sequences and
// random beam traffic, all checked against a sequence-index reference model.
module tb_gate_beam_sequencer;
    localparam int TMO = 8;

    logic clk;
    logic reset;
    gate_beam_sequencer_if bus ();

    gate_beam_sequencer #(.TIMEOUT_CYCLES(TMO), .TW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: dir 0=idle 1=inbound 2=outbound 3=fault; idx = position in the beam pattern sequence
    int         m_dir, m_idx, m_dwell;
    logic       m_entry, m_exit;
    logic [1:0] d1, d2;

    int entry_seen, exit_seen, fault_seen, space_cnt;

    typedef struct {
        logic [7:0] seq;
        int         n_entry;
        int         n_exit;
        logic       end_busy;
        logic       end_fault;
    } vec_t;
    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] pat(input int dir, input int idx);
        case (idx)
            0:       return (dir == 1) ? 2'b10 : 2'b01;
            1:       return 2'b11;
            default: return (dir == 1) ? 2'b01 : 2'b10;
        endcase
    endfunction

    task automatic model_update(input logic [1:0] p);
        bit moved;
        m_entry = 1'b0;
        m_exit  = 1'b0;
        moved   = 1'b0;
        if (m_dir == 0) begin
            if (p == 2'b10) begin m_dir = 1; m_idx = 0; end
            else if (p == 2'b01) begin m_dir = 2; m_idx = 0; end
            else if (p == 2'b11) m_dir = 3;
            m_dwell = 0;
        end else if (m_dir == 3) begin
            if (p == 2'b00) m_dir = 0;
            m_dwell = 0;
        end else begin
            if (p != pat(m_dir, m_idx)) begin
                moved = 1'b1;
                if (p == 2'b00) begin
                    if (m_idx == 2) begin
                        if (m_dir == 1) m_entry = 1'b1;
                        else m_exit = 1'b1;
                    end
                    m_dir = 0;
                end else if (m_idx < 2 && p == pat(m_dir, m_idx + 1)) m_idx++;
                else if (m_idx > 0 && p == pat(m_dir, m_idx - 1)) m_idx--;
                else m_dir = 3;
            end
            if (moved) m_dwell = 0;
            else if (m_dwell == TMO - 1) begin m_dir = 3; m_dwell = 0; end
            else m_dwell++;
        end
    endtask

    task automatic step(input logic [1:0] beams, input logic rst);
        bus.beam_outer = beams[1];
        bus.beam_inner = beams[0];
        reset = rst;
        @(posedge clk);
        if (rst) begin
            m_dir = 0; m_idx = 0; m_dwell = 0;
            m_entry = 1'b0; m_exit = 1'b0;
            d1 = 2'b00; d2 = 2'b00;
        end else begin
            model_update(d2);
            d2 = d1;
            d1 = beams;
        end
        #1;
        check("model_entry", bus.entry_pulse, m_entry);
        check("model_exit",  bus.exit_pulse,  m_exit);
        check("model_busy",  bus.busy,  (m_dir == 1 || m_dir == 2));
        check("model_fault", bus.fault, (m_dir == 3));
        if (bus.entry_pulse === 1'b1) begin entry_seen++; space_cnt--; end
        if (bus.exit_pulse === 1'b1) begin exit_seen++; space_cnt++; end
        if (bus.fault === 1'b1) fault_seen++;
    endtask

    task automatic hold(input logic [1:0] p, input int n);
        for (int k = 0; k < n; k++) step(p, 1'b0);
    endtask

    task automatic clear_counts();
        entry_seen = 0; exit_seen = 0; fault_seen = 0;
    endtask

    task automatic entry_seq();
        hold(2'b10, 4); hold(2'b11, 4); hold(2'b01, 4); hold(2'b00, 4);
    endtask

    initial begin
        int busy_at, fault_at, first;
        logic [1:0] p;

        vecs[0] = '{8'b10_11_01_00, 1, 0, 1'b0, 1'b0};
        vecs[1] = '{8'b01_11_10_00, 0, 1, 1'b0, 1'b0};
        vecs[2] = '{8'b10_11_10_00, 0, 0, 1'b0, 1'b0};
        vecs[3] = '{8'b01_11_01_00, 0, 0, 1'b0, 1'b0};
        vecs[4] = '{8'b10_11_00_00, 0, 0, 1'b0, 1'b0};
        vecs[5] = '{8'b10_01_01_01, 0, 0, 1'b0, 1'b1};
        vecs[6] = '{8'b11_11_11_11, 0, 0, 1'b0, 1'b1};
        vecs[7] = '{8'b10_11_01_10, 0, 0, 1'b0, 1'b1};
        vecs[8] = '{8'b01_11_10_11, 0, 0, 1'b1, 1'b0};

        space_cnt = 0;
        clear_counts();
        step(2'b00, 1'b1);
        step(2'b00, 1'b1);
        check("reset_entry", bus.entry_pulse, 1'b0);
        check("reset_exit",  bus.exit_pulse,  1'b0);
        check("reset_busy",  bus.busy,  1'b0);
        check("reset_fault", bus.fault, 1'b0);
        hold(2'b00, 3);

        for (int v = 0; v < 9; v++) begin
            clear_counts();
            for (int k = 0; k < 4; k++) begin
                p = vecs[v].seq[(3 - k) * 2 +: 2];
                hold(p, 4);
            end
            check("vec_end_busy",  bus.busy,  vecs[v].end_busy);
            check("vec_end_fault", bus.fault, vecs[v].end_fault);
            hold(2'b00, 6);
            check("vec_entry_count", entry_seen, vecs[v].n_entry);
            check("vec_exit_count",  exit_seen,  vecs[v].n_exit);
            check("vec_idle_busy",   bus.busy,  1'b0);
            check("vec_idle_fault",  bus.fault, 1'b0);
        end

        // Entry latency: pulse three edges after the closing (0,0)
        clear_counts();
        hold(2'b10, 4); hold(2'b11, 4); hold(2'b01, 4);
        first = 0;
        for (int k = 1; k <= 6; k++) begin
            step(2'b00, 1'b0);
            if (bus.entry_pulse === 1'b1 && first == 0) first = k;
        end
        check("entry_latency", first, 3);
        check("entry_once", entry_seen, 1);
        check("entry_no_exit", exit_seen, 0);

        // Dwell timeout in IN_O
        clear_counts();
        busy_at = 0; fault_at = 0;
        for (int k = 1; k <= 20; k++) begin
            step(2'b10, 1'b0);
            if (bus.busy === 1'b1 && busy_at == 0) busy_at = k;
            if (bus.fault === 1'b1 && fault_at == 0) fault_at = k;
        end
        check("tmo_enter_in_o", busy_at, 3);
        check("tmo_fault_delay", fault_at - busy_at, TMO);
        hold(2'b00, 6);
        check("tmo_recover_fault", bus.fault, 1'b0);
        check("tmo_no_pulse", entry_seen + exit_seen, 0);

        // Transition on the last dwell cycle wins; one cycle later it is a fault
        clear_counts();
        hold(2'b10, 8); hold(2'b11, 4); hold(2'b01, 4); hold(2'b00, 4);
        check("edge_tmo_no_fault", fault_seen, 0);
        check("edge_tmo_entry", entry_seen, 1);
        clear_counts();
        hold(2'b10, 9); hold(2'b11, 4); hold(2'b01, 4); hold(2'b00, 4);
        check("late_tmo_faulted", fault_seen > 0, 1'b1);
        check("late_tmo_no_entry", entry_seen, 0);

        // Reset in IN_I abandons the vehicle
        clear_counts();
        hold(2'b10, 4); hold(2'b11, 4); hold(2'b01, 4);
        check("in_i_busy", bus.busy, 1'b1);
        step(2'b01, 1'b1);
        hold(2'b00, 6);
        check("rst_mid_no_entry", entry_seen, 0);
        check("rst_mid_busy", bus.busy, 1'b0);
        check("rst_mid_fault", bus.fault, 1'b0);

        // Back-to-back entries against a downstream space counter
        clear_counts();
        space_cnt = 10;
        entry_seq();
        entry_seq();
        check("b2b_entries", entry_seen, 2);
        check("b2b_spaces", space_cnt, 8);

        // Random traffic with occasional reset
        for (int s = 0; s < 300; s++) begin
            p = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) step(p, 1'b1);
            else hold(p, int'($urandom_range(1, 10)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gate_beam_sequencer.md
GATE_BEAM_SEQUENCER -- requirements
Module: gate_beam_sequencer

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 1000, maximum cycles allowed in any one in-progress state before a fault is declared.
REQ-002 Parameter: TW, 10, width of the timeout counter; the block SHALL require TIMEOUT_CYCLES <= 2**TW.
REQ-003 Port: clk  input  1  system clock; all logic on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: beam_outer  input  1  outer (street-side) IR beam, 1 = blocked, asynchronous.
REQ-006 Port: beam_inner  input  1  inner (lot-side) IR beam, 1 = blocked, asynchronous.
REQ-007 Port: entry_pulse  output  1  one-cycle pulse per completed inbound vehicle; drives a space counter's entry input.
REQ-008 Port: exit_pulse  output  1  one-cycle pulse per completed outbound vehicle; drives a space counter's exit input.
REQ-009 Port: busy  output  1  high while the FSM is in any state other than IDLE or FAULT.
REQ-010 Port: fault  output  1  high while the FSM is in FAULT.

Function
REQ-011 Each beam SHALL pass through a 2-flop synchronizer; the FSM uses only the synchronized values, written (o,i) below.
REQ-012 FSM states: IDLE, IN_O, IN_OI, IN_I, OUT_I, OUT_IO, OUT_O, FAULT.
REQ-013 IDLE: (1,0)->IN_O; (0,1)->OUT_I; (1,1)->FAULT; (0,0) stay.
REQ-014 IN_O: (1,1)->IN_OI; (0,0)->IDLE, no pulse (backed out); (0,1)->FAULT; (1,0) stay.
REQ-015 IN_OI: (0,1)->IN_I; (1,0)->IN_O (reversing); (0,0)->IDLE, no pulse; (1,1) stay.
REQ-016 IN_I: (0,0)->IDLE and assert entry_pulse; (1,1)->IN_OI; (1,0)->FAULT; (0,1) stay.
REQ-017 OUT_I/OUT_IO/OUT_O SHALL mirror REQ-014..016 with beams swapped; OUT_O with (0,0) asserts exit_pulse.
REQ-018 entry_pulse/exit_pulse SHALL be registered, high for exactly one cycle, never both in the same cycle.
REQ-019 Latency: a raw beam change captured at edge N SHALL produce its state change and any pulse at edge N+2, visible during the following cycle.
REQ-020 The timeout counter SHALL clear on every state change and in IDLE/FAULT, and increment each cycle otherwise.
REQ-021 When the counter equals TIMEOUT_CYCLES-1 and no transition occurs, the FSM SHALL enter FAULT on that edge with no pulse.
REQ-022 A legal transition and a timeout on the same edge SHALL resolve in favour of the transition.
REQ-023 FAULT SHALL exit to IDLE only on observing (0,0); no pulse is generated on that exit.
REQ-024 Counter arithmetic SHALL be unsigned TW bits and SHALL never wrap, because the counter saturates into FAULT.

Reset
REQ-025 Reset SHALL set the FSM to IDLE, clear the timeout counter and synchronizer flops, and drive entry_pulse=0, exit_pulse=0, busy=0, fault=0.
REQ-026 Reset asserted mid-sequence SHALL abandon the sequence with no pulse; the next pulse requires a complete new sequence.
REQ-027 Reset SHALL take priority over all other inputs on the same edge.

Structure
REQ-028 Package parking_pkg SHALL hold the FSM state typedef and the default TIMEOUT_CYCLES constant.
REQ-029 The synchronizer SHALL be a sub-module named beam_sync, instantiated once per beam.
REQ-030 Outputs busy and fault SHALL decode from the registered state only.

Verification (bench TIMEOUT_CYCLES=8)
REQ-031 Beams (1,0)->(1,1)->(0,1)->(0,0), each held 4 cycles -> exactly one entry_pulse, 3 edges after the final (0,0) is applied; exit_pulse stays 0.
REQ-032 Beams (0,1)->(1,1)->(1,0)->(0,0) -> exactly one exit_pulse; no entry_pulse.
REQ-033 Beams (1,0)->(1,1)->(1,0)->(0,0) (reversal) -> no pulses; FSM ends in IDLE and busy=0.
REQ-034 Beam (1,0) held 20 cycles -> fault=1 on the 8th cycle after entering IN_O; apply (0,0) -> fault=0 and no pulse.
REQ-035 Reset asserted while in IN_I, released, then (0,0) applied -> no entry_pulse; all outputs 0.
REQ-036 Two back-to-back entry sequences -> two separate one-cycle entry_pulses; a downstream space counter decrements by 2.
